// File: rtl/sm83_intc.sv
// SM83 interrupt controller: IF/IE registers, IME, priority select and dispatch vector.
// Build option SM83_INTC_EI_DELAY_EN: EI takes effect at the next instruction boundary.
module sm83_intc #(
   parameter int          NUM_IRQ  = 5,
   parameter logic [15:0] VEC_BASE = 16'h0040
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [15:0]        i_addr,
   input  logic [7:0]         i_d_cpu,
   input  logic               i_write,
   output logic [7:0]         o_rd_data,
   output logic               o_rd_hit,
   input  logic [NUM_IRQ-1:0] i_irq_in,
   input  logic               i_ei,
   input  logic               i_di,
   input  logic               i_reti,
   input  logic               i_insn_boundary,
   input  logic               i_int_ack,
   output logic               o_int_req,
   output logic               o_wake,
   output logic [15:0]        o_vector
);

   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   logic [NUM_IRQ-1:0] r_if;
   logic [NUM_IRQ-1:0] r_irq_prev;
   logic [7:0]         r_ie;
   logic               r_ime;
   logic [15:0]        r_vector;

   logic [NUM_IRQ-1:0] w_pend;
   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] w_sel;
   logic [NUM_IRQ-1:0] w_if_nxt;
   logic [15:0]        w_vec_sel;
   logic               w_ime_nxt;
   logic               w_wr_if;
   logic               w_wr_ie;

   assign w_pend  = r_if & r_ie[NUM_IRQ-1:0];
   assign w_rise  = i_irq_in & ~r_irq_prev;
   assign w_wr_if = i_write && (i_addr == ADDR_IF);
   assign w_wr_ie = i_write && (i_addr == ADDR_IE);

   // Scan from the top down so the lowest pending bit is the one left selected.
   always_comb begin
      w_sel     = '0;
      w_vec_sel = 16'h0000;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_pend[i]) begin
            w_sel     = '0;
            w_sel[i]  = 1'b1;
            w_vec_sel = VEC_BASE + 16'(8 * i);
         end
      end
   end

   // A rising edge is ORed in last so a request can never be lost to an ack or write.
   always_comb begin
      w_if_nxt = r_if;
      if (i_int_ack) w_if_nxt = r_if & ~w_sel;
      if (w_wr_if)   w_if_nxt = i_d_cpu[NUM_IRQ-1:0];
      w_if_nxt = w_if_nxt | w_rise;
   end

`ifdef SM83_INTC_EI_DELAY_EN
   logic r_ei_pend;
   logic w_ei_pend_nxt;

   always_comb begin
      w_ime_nxt     = r_ime;
      w_ei_pend_nxt = r_ei_pend;
      if (i_int_ack || i_di) begin
         w_ime_nxt     = 1'b0;
         w_ei_pend_nxt = 1'b0;
      end else if (i_reti) begin
         w_ime_nxt = 1'b1;
      end else if (r_ei_pend && i_insn_boundary) begin
         w_ime_nxt     = 1'b1;
         w_ei_pend_nxt = 1'b0;
      end else if (i_ei && !r_ime) begin
         w_ei_pend_nxt = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_ei_pend <= 1'b0;
      else          r_ei_pend <= w_ei_pend_nxt;
   end
`else
   logic w_unused_boundary;
   assign w_unused_boundary = i_insn_boundary;

   always_comb begin
      w_ime_nxt = r_ime;
      if (i_int_ack || i_di) w_ime_nxt = 1'b0;
      else if (i_reti || i_ei) w_ime_nxt = 1'b1;
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_if       <= '0;
         r_irq_prev <= '0;
         r_ie       <= 8'h00;
         r_ime      <= 1'b0;
         r_vector   <= 16'h0000;
      end else begin
         r_if       <= w_if_nxt;
         r_irq_prev <= i_irq_in;
         r_ime      <= w_ime_nxt;
         if (w_wr_ie)   r_ie     <= i_d_cpu;
         if (i_int_ack) r_vector <= w_vec_sel;
      end
   end

   always_comb begin
      o_rd_data = 8'h00;
      if (i_addr == ADDR_IF)      o_rd_data = {{(8 - NUM_IRQ){1'b1}}, r_if};
      else if (i_addr == ADDR_IE) o_rd_data = r_ie;
   end

   assign o_rd_hit  = (i_addr == ADDR_IF) || (i_addr == ADDR_IE);
   assign o_int_req = r_ime && (|w_pend);
   assign o_wake    = |w_pend;
   assign o_vector  = r_vector;

endmodule

// File: doc/sm83_intc.md
# sm83_intc

Interrupt controller sitting directly upstream of the `sm83` core. It latches peripheral interrupt requests into the IF register and holds the IE mask and the IME master enable. It presents a pending-interrupt request and dispatch vector to the core's sequencer, and decodes the core's memory bus for IF (0xFF0F) and IE (0xFFFF) register access.

## Interface
Parameters:
- `NUM_IRQ`, 5: number of request lines; bit 0 has the highest priority.
- `VEC_BASE`, 16'h0040: vector of bit 0; bit k vectors to `VEC_BASE + 8*k`.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `addr` in 16: core address bus.
- `d_cpu` in 8: core write data (`sm83.d_out`).
- `write` in 1: core write strobe, qualifies `addr`/`d_cpu` this cycle.
- `rd_data` out 8: read data for IF/IE; 8'h00 when no hit.
- `rd_hit` out 1: `addr` is 0xFF0F or 0xFFFF.
- `irq_in` in NUM_IRQ: peripheral request lines, rising-edge sensitive.
- `ei` in 1: EI executed (1-cycle pulse).
- `di` in 1: DI executed (1-cycle pulse).
- `reti` in 1: RETI executed; sets IME immediately.
- `insn_boundary` in 1: opcode fetch completed (1-cycle pulse).
- `int_ack` in 1: core begins interrupt dispatch (1-cycle pulse).
- `int_req` out 1: IME & any enabled pending request.
- `wake` out 1: any enabled pending request, regardless of IME (HALT exit).
- `vector` out 16: dispatch target, registered at `int_ack`.

## Operation
- State: `if_r[NUM_IRQ-1:0]`, `ie_r[7:0]`, `ime`, `ei_pend`, `irq_prev[NUM_IRQ-1:0]`, `vector`.
- Pending mask: `pend = if_r & ie_r[NUM_IRQ-1:0]`. `int_req = ime & |pend`. `wake = |pend`.
- Edge detect: `rise = irq_in & ~irq_prev`. `irq_prev <= irq_in` every cycle.
- IF update, priority low to high:
  - hold;
  - ack clear of the selected bit;
  - CPU write `write && addr==16'hFF0F` loads `d_cpu[NUM_IRQ-1:0]`;
  - OR with `rise`. A rising edge always wins; a request is never lost.
- IE: `write && addr==16'hFFFF` loads all 8 bits of `d_cpu`.
- Reads are combinational:
  - 0xFF0F returns `{(8-NUM_IRQ) ones, if_r}`, i.e. 8'hE0|IF for 5 lines.
  - 0xFFFF returns `ie_r`.
- `int_ack`:
  - selected bit k = lowest set bit of `pend`;
  - clear `if_r[k]`, `vector <= VEC_BASE + 8*k`, `ime <= 0`, `ei_pend <= 0`;
  - if `pend==0` (request cancelled by an IE/IF write), `vector <= 16'h0000`, no IF change, IME still cleared.
- IME control, priority high to low:
  1. `int_ack` → 0.
  2. `di` → 0, `ei_pend <= 0`.
  3. `reti` → 1.
  4. EI handling, per Configuration.
- `ei` while IME=1: no effect.

## Timing
- Reset values:
  - `if_r`, `ie_r`, `ime`, `ei_pend`, `irq_prev` = 0; `vector` = 16'h0000.
  - Outputs: `int_req`=0, `wake`=0.
- An `irq_in` held high through reset release counts as an edge on the first clock after release.
- Request latency:
  - `irq_in` rises in cycle n; `if_r` is set at edge n.
  - `int_req`/`wake` are high in cycle n+1, provided IE and IME already allow it.
- Register write in cycle n is visible on `rd_data` and `pend` in cycle n+1.
- `vector` is valid from cycle n+1 after `int_ack` in cycle n, and is held until the next ack.
- `int_req` drops in the cycle after `int_ack` because IME is cleared.
- Reset asserted mid-operation clears all state asynchronously. A dispatch in progress yields `vector`=0.

## Configuration
- `SM83_INTC_EI_DELAY_EN` defined:
  - `ei` sets `ei_pend`;
  - IME becomes 1 at the first `insn_boundary` strictly after the `ei` cycle;
  - `ei` and `insn_boundary` in the same cycle do not enable IME.
- Undefined: `ei` sets IME on the next edge; `ei_pend` is tied 0.

## Test plan
- IME=1, IE=8'h1F, pulse `irq_in`=5'b00100 → `int_req`=1 next cycle; `int_ack` → `vector`=16'h0050, IF bit2 clear, IME=0.
- `irq_in`=5'b10101 simultaneously, then `int_ack` three times with IME re-set via `reti` → vectors 0x0040, 0x0050, 0x0060 in that order.
- Write 0xFF0F=8'h00 in the same cycle as a rising `irq_in[1]` → read 0xFF0F returns 8'hE2.
- IME=0, IE=8'h01, raise `irq_in[0]` → `wake`=1, `int_req`=0; write 0xFFFF=8'h00 → `wake`=0 next cycle.
- `SM83_INTC_EI_DELAY_EN`: `ei` then `insn_boundary` two cycles later with pending IRQ → `int_req` rises only after that boundary. Without the macro → `int_req` rises the cycle after `ei`.
- `int_ack` after IE cleared the pending bit → `vector`=16'h0000, IME=0.
